// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: mode codes, burst FSM states
// and shift direction.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_LEFT) || (m == MODE_RIGHT);
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: IDLE/RUN FSM, remaining-shift counter and busy/done handshake.
// Emits the per-cycle shift strobe, direction and rotate select for the datapath.
module shift_burst_ctrl
  import shift_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_rotate,
  output logic             o_shift,
  output logic             o_dir,
  output logic             o_rot,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_dir;
  logic             r_rot;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic             w_dir_nxt;
  logic             w_rot_nxt;
  logic             w_done_nxt;
  logic             w_shift;
  logic             w_dir;
  logic             w_rot;

  // Next-state, counter and per-cycle shift strobe
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_dir_nxt       = r_dir;
    w_rot_nxt       = r_rot;
    w_done_nxt      = 1'b0;
    w_shift         = 1'b0;
    w_dir           = r_dir;
    w_rot           = r_rot;
    case (r_state)
      ST_IDLE: begin
        w_dir = (i_mode == MODE_LEFT) ? DIR_LEFT : DIR_RIGHT;
        w_rot = i_rotate;
        if (i_start && is_shift_mode(i_mode)) begin
          // An accepted start never shifts on its own edge, even with enable high.
          if (i_count != CNT_ZERO) begin
            w_state_nxt     = ST_RUN;
            w_remaining_nxt = i_count;
            w_dir_nxt       = w_dir;
            w_rot_nxt       = i_rotate;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_shift = i_enable && is_shift_mode(i_mode);
        end
      end
      ST_RUN: begin
        if (i_enable) begin
          w_shift         = 1'b1;
          w_remaining_nxt = r_remaining - CNT_ONE;
          if (r_remaining == CNT_ONE) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_shift = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = CNT_ZERO;
      end
    endcase
  end

  // FSM, counter, latched burst settings and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= CNT_ZERO;
      r_dir       <= DIR_RIGHT;
      r_rot       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_dir       <= w_dir_nxt;
      r_rot       <= w_rot_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_shift = w_shift;
  assign o_dir   = w_dir;
  assign o_rot   = w_rot;
  assign o_busy  = (r_state == ST_RUN);
  assign o_done  = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// SIZE-stage, LANE-bit universal shift register with hold/left/right/load and burst mode.
// Optional USR_ROTATE_EN adds a rotate input that recirculates the shifted-out lane.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int LANE  = 1,
  localparam int CNT_W = $clog2(SIZE + 1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [LANE-1:0]      in_lsb,
  input  logic [LANE-1:0]      in_msb,
  input  logic [SIZE*LANE-1:0] load_data,
  input  logic                 start,
  input  logic [CNT_W-1:0]     count,
`ifdef USR_ROTATE_EN
  input  logic                 rotate,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [SIZE*LANE-1:0] full_out,
  output logic [LANE-1:0]      out_msb,
  output logic [LANE-1:0]      out_lsb
);

  logic [LANE-1:0] r_stage     [SIZE];
  logic [LANE-1:0] w_stage_nxt [SIZE];
  logic            w_shift;
  logic            w_dir;
  logic            w_rot;
  logic            w_rotate_in;
  logic            w_load;
  logic [LANE-1:0] w_fill_left;
  logic [LANE-1:0] w_fill_right;

`ifdef USR_ROTATE_EN
  assign w_rotate_in = rotate;
`else
  assign w_rotate_in = 1'b0;
`endif

  shift_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .i_mode   (mode),
    .i_start  (start),
    .i_count  (count),
    .i_rotate (w_rotate_in),
    .o_shift  (w_shift),
    .o_dir    (w_dir),
    .o_rot    (w_rot),
    .o_busy   (busy),
    .o_done   (done)
  );

  assign w_load       = enable && (mode == MODE_LOAD) && !busy;
  assign w_fill_left  = w_rot ? r_stage[SIZE-1] : in_lsb;
  assign w_fill_right = w_rot ? r_stage[0]      : in_msb;

  // Next stage contents: shift takes priority; load only reachable outside a burst
  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      w_stage_nxt[k] = r_stage[k];
    end
    if (w_shift && (w_dir == DIR_LEFT)) begin
      w_stage_nxt[0] = w_fill_left;
      for (int k = 1; k < SIZE; k++) begin
        w_stage_nxt[k] = r_stage[k-1];
      end
    end else if (w_shift) begin
      w_stage_nxt[SIZE-1] = w_fill_right;
      for (int k = 0; k < SIZE - 1; k++) begin
        w_stage_nxt[k] = r_stage[k+1];
      end
    end else if (w_load) begin
      for (int k = 0; k < SIZE; k++) begin
        w_stage_nxt[k] = load_data[k*LANE +: LANE];
      end
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        w_stage_nxt[k] = r_stage[k];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SIZE; k++) begin
        r_stage[k] <= {LANE{1'b0}};
      end
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        r_stage[k] <= w_stage_nxt[k];
      end
    end
  end

  // Flatten stages onto the parallel output
  always_comb begin
    full_out = {(SIZE*LANE){1'b0}};
    for (int k = 0; k < SIZE; k++) begin
      full_out[k*LANE +: LANE] = r_stage[k];
    end
  end

  assign out_msb = r_stage[SIZE-1];
  assign out_lsb = r_stage[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (SIZE=8, LANE=1);
// with USR_ROTATE_EN defined it adds a SIZE=4, LANE=4 instance for rotate bursts.
module tb_universal_shift_register;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       in_lsb;
  logic       in_msb;
  logic [7:0] load_data;
  logic       start;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic [7:0] full_out;
  logic       out_msb;
  logic       out_lsb;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef USR_ROTATE_EN
  logic        rot1;
  logic        en2;
  logic [1:0]  mode2;
  logic [3:0]  lsb2;
  logic [3:0]  msb2;
  logic [15:0] ld2;
  logic        start2;
  logic [3:0]  cnt2;
  logic        rot2;
  logic        busy2;
  logic        done2;
  logic [15:0] full2;
  logic [3:0]  omsb2;
  logic [3:0]  olsb2;
`endif

  universal_shift_register #(.SIZE(8), .LANE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .in_lsb    (in_lsb),
    .in_msb    (in_msb),
    .load_data (load_data),
    .start     (start),
    .count     (count),
`ifdef USR_ROTATE_EN
    .rotate    (rot1),
`endif
    .busy      (busy),
    .done      (done),
    .full_out  (full_out),
    .out_msb   (out_msb),
    .out_lsb   (out_lsb)
  );

`ifdef USR_ROTATE_EN
  universal_shift_register #(.SIZE(4), .LANE(4)) dut_rot (
    .clk       (clk),
    .reset     (reset),
    .enable    (en2),
    .mode      (mode2),
    .in_lsb    (lsb2),
    .in_msb    (msb2),
    .load_data (ld2),
    .start     (start2),
    .count     (cnt2),
    .rotate    (rot2),
    .busy      (busy2),
    .done      (done2),
    .full_out  (full2),
    .out_msb   (omsb2),
    .out_lsb   (olsb2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    reset = 1'b1; enable = 1'b0; mode = 2'b00; in_lsb = 1'b0; in_msb = 1'b0;
    load_data = 8'h00; start = 1'b0; count = 5'd0;
`ifdef USR_ROTATE_EN
    rot1 = 1'b0; en2 = 1'b0; mode2 = 2'b00; lsb2 = 4'h0; msb2 = 4'h0;
    ld2 = 16'h0000; start2 = 1'b0; cnt2 = 4'd0; rot2 = 1'b0;
`endif
    tick();
    check_eq("rst_full", {24'd0, full_out}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);
    check_eq("rst_done", {31'd0, done}, 32'h0);
    check_eq("rst_msb_lsb", {30'd0, out_msb, out_lsb}, 32'h0);
    reset = 1'b0;

    // Direct modes
    enable = 1'b1; mode = 2'b11; load_data = 8'h81; tick();
    check_eq("load_81", {24'd0, full_out}, 32'h81);
    check_eq("load_81_msb", {31'd0, out_msb}, 32'h1);
    mode = 2'b01; in_lsb = 1'b1; tick();
    check_eq("left_03", {24'd0, full_out}, 32'h03);
    mode = 2'b10; in_msb = 1'b0; tick();
    check_eq("right_01", {24'd0, full_out}, 32'h01);
    check_eq("right_01_lsb", {31'd0, out_lsb}, 32'h1);
    enable = 1'b0; mode = 2'b01; tick();
    check_eq("en_low_hold", {24'd0, full_out}, 32'h01);
    enable = 1'b1; mode = 2'b00; tick();
    check_eq("mode_hold", {24'd0, full_out}, 32'h01);

    // Burst left x3 from 0x01; mode forced to load during RUN must be ignored
    mode = 2'b01; start = 1'b1; count = 5'd3; in_lsb = 1'b0; tick();
    check_eq("bl_start_busy", {31'd0, busy}, 32'h1);
    check_eq("bl_start_noshift", {24'd0, full_out}, 32'h01);
    start = 1'b0; mode = 2'b11; load_data = 8'hFF; tick();
    check_eq("bl_s1", {24'd0, full_out}, 32'h02);
    check_eq("bl_s1_done", {31'd0, done}, 32'h0);
    tick();
    check_eq("bl_s2", {24'd0, full_out}, 32'h04);
    check_eq("bl_s2_busy", {31'd0, busy}, 32'h1);
    tick();
    check_eq("bl_final", {24'd0, full_out}, 32'h08);
    check_eq("bl_final_busy", {31'd0, busy}, 32'h0);
    check_eq("bl_final_done", {31'd0, done}, 32'h1);
    mode = 2'b00; tick();
    check_eq("bl_done_pulse", {31'd0, done}, 32'h0);

    // Burst right x4 from 0x80 with a 2-cycle stall
    mode = 2'b11; load_data = 8'h80; tick();
    mode = 2'b10; start = 1'b1; count = 5'd4; in_msb = 1'b0;
    busy_cycles = 0;
    tick(); busy_cycles += busy;
    start = 1'b0; mode = 2'b00;
    tick(); busy_cycles += busy;
    check_eq("br_s1", {24'd0, full_out}, 32'h40);
    enable = 1'b0;
    tick(); busy_cycles += busy;
    tick(); busy_cycles += busy;
    check_eq("br_stall", {24'd0, full_out}, 32'h40);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); busy_cycles += busy;
    end
    check_eq("br_busy_cycles", busy_cycles, 32'd6);
    check_eq("br_final", {24'd0, full_out}, 32'h08);

    // count=0 then back-to-back count=10 (> SIZE)
    mode = 2'b01; start = 1'b1; count = 5'd0; in_lsb = 1'b1; tick();
    check_eq("c0_done", {31'd0, done}, 32'h1);
    check_eq("c0_busy", {31'd0, busy}, 32'h0);
    check_eq("c0_noshift", {24'd0, full_out}, 32'h08);
    count = 5'd10; tick();
    check_eq("c10_busy", {31'd0, busy}, 32'h1);
    check_eq("c10_done_low", {31'd0, done}, 32'h0);
    check_eq("c10_noshift", {24'd0, full_out}, 32'h08);
    start = 1'b0; mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) check_eq("c10_mid", {24'd0, full_out}, 32'h1F);
    end
    check_eq("c10_full", {24'd0, full_out}, 32'hFF);
    check_eq("c10_done", {31'd0, done}, 32'h1);
    check_eq("c10_busy_end", {31'd0, busy}, 32'h0);

    // Reset in the middle of a 5-shift burst
    mode = 2'b11; load_data = 8'hA5; tick();
    mode = 2'b01; start = 1'b1; count = 5'd5; in_lsb = 1'b0; tick();
    start = 1'b0; mode = 2'b00;
    tick(); tick();
    check_eq("rm_two_shifts", {24'd0, full_out}, 32'h94);
    #3 reset = 1'b1;
    #1;
    check_eq("rm_full", {24'd0, full_out}, 32'h00);
    check_eq("rm_busy", {31'd0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rm_no_done", {30'd0, busy, done}, 32'h0);
    end
    check_eq("rm_full_after", {24'd0, full_out}, 32'h00);

`ifdef USR_ROTATE_EN
    en2 = 1'b1; mode2 = 2'b11; ld2 = 16'h1234; tick();
    check_eq("rot_load", {16'd0, full2}, 32'h1234);
    mode2 = 2'b01; start2 = 1'b1; cnt2 = 4'd1; rot2 = 1'b1; tick();
    start2 = 1'b0; mode2 = 2'b00; rot2 = 1'b0; lsb2 = 4'hF; tick();
    check_eq("rot_c1", {16'd0, full2}, 32'h2341);
    check_eq("rot_c1_done", {31'd0, done2}, 32'h1);
    mode2 = 2'b11; ld2 = 16'h1234; tick();
    mode2 = 2'b01; start2 = 1'b1; cnt2 = 4'd4; rot2 = 1'b1; tick();
    start2 = 1'b0; mode2 = 2'b00; rot2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rot_c4", {16'd0, full2}, 32'h1234);
    check_eq("rot_c4_done", {31'd0, done2}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
